// File: rtl/prio_arbiter_if.sv
// rtl/prio_arbiter_if.sv - request/grant bundle between requesters, arbiter and grant consumer
//
// Purpose: groups the arbiter's request inputs and its valid/ready grant stream.
// Signals:
//   mode          0 = fixed priority (index N-1 highest), 1 = round-robin
//   req[N]        request vector, bit i = requester i wants a grant
//   grant_valid   a grant is being presented
//   grant_ready   consumer accepts the grant this cycle
//   grant_idx     binary index of the granted requester
//   grant_onehot  one-hot form of the granted requester
//   busy          a grant is pending acceptance
// Modports: master = arbiter side (drives the grant), slave = requester/consumer side.
interface prio_arbiter_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic             mode;
    logic [N-1:0]     req;
    logic             grant_valid;
    logic             grant_ready;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     grant_onehot;
    logic             busy;

    modport master (
        input  mode, req, grant_ready,
        output grant_valid, grant_idx, grant_onehot, busy
    );

    modport slave (
        output mode, req, grant_ready,
        input  grant_valid, grant_idx, grant_onehot, busy
    );
endinterface

// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - registered fixed-priority / round-robin arbiter with valid/ready grant
//
// Purpose: picks one of N requesters (highest index in fixed mode, descending
// rotating search from ptr in round-robin mode), registers the winner and holds
// it until the consumer accepts it. One idle cycle follows every handshake.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    prio_arbiter_if.master (mode, req, grant_ready in; grant_valid,
//          grant_idx, grant_onehot, busy out)
module prio_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    prio_arbiter_if.master   bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             rr_q, rr_d;

    logic [N-1:0]     low_mask;
    logic [N-1:0]     low_req;
    logic [IDX_W-1:0] win_all;
    logic [IDX_W-1:0] win_low;
    logic [IDX_W-1:0] win_idx;

    function automatic logic [IDX_W-1:0] highest(input logic [N-1:0] v);
        highest = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) highest = IDX_W'(i);
        end
    endfunction

    // Round-robin descends from ptr and wraps to N-1, which is the same as:
    // highest set bit at or below ptr if there is one, otherwise highest set
    // bit overall. When ptr = N-1 the shift overflows to zero and the mask
    // becomes all ones, which is exactly the wanted behaviour.
    always_comb begin
        low_mask = (N'(2) << ptr_q) - N'(1);
        low_req  = bus.req & low_mask;
        win_all  = highest(bus.req);
        win_low  = highest(low_req);
        if (bus.mode && (|low_req)) win_idx = win_low;
        else                        win_idx = win_all;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;
        rr_d     = rr_q;
        if (state_q == IDLE) begin
            if (|bus.req) begin
                state_d  = HOLD;
                idx_d    = win_idx;
                onehot_d = N'(1) << win_idx;
                rr_d     = bus.mode;
            end
        end else begin
            if (bus.grant_ready) begin
                state_d  = IDLE;
                onehot_d = '0;
                // The mode captured with the grant decides whether ptr moves,
                // so mode changes during HOLD cannot disturb the rotation.
                if (rr_q) begin
                    ptr_d = (idx_q == '0) ? IDX_W'(N - 1) : idx_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= IDX_W'(N - 1);
            rr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
            rr_q     <= rr_d;
        end
    end

    assign bus.grant_valid  = (state_q == HOLD);
    assign bus.busy         = (state_q == HOLD);
    assign bus.grant_idx    = idx_q;
    assign bus.grant_onehot = onehot_q;
endmodule

// File: tb/tb_prio_arbiter.sv
// tb/tb_prio_arbiter.sv - self-checking bench for prio_arbiter (N=8 and N=5 instances)
module tb_prio_arbiter;
    logic clk;
    logic rst_n;

    prio_arbiter_if #(.N(8), .IDX_W(3)) if8 ();
    prio_arbiter_if #(.N(5), .IDX_W(3)) if5 ();

    prio_arbiter #(.N(8), .IDX_W(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    prio_arbiter #(.N(5), .IDX_W(3)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_n[2] = '{8, 5};
    bit m_hold[2];
    int m_idx[2];
    int m_ptr[2];
    bit m_rr[2];

    function automatic int pick(input logic [63:0] r, input bit rr, input int p, input int n);
        if (!rr) begin
            for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < n; k++) begin
                int c;
                c = (p - k + n) % n;
                if (r[c]) return c;
            end
        end
        return -1;
    endfunction

    task automatic model_step(input int j, input logic [63:0] r, input bit md, input bit rdy);
        int w;
        if (m_hold[j]) begin
            if (rdy) begin
                m_hold[j] = 0;
                if (m_rr[j]) m_ptr[j] = (m_idx[j] == 0) ? m_n[j] - 1 : m_idx[j] - 1;
            end
        end else begin
            w = pick(r, md, m_ptr[j], m_n[j]);
            if (w >= 0) begin
                m_hold[j] = 1;
                m_idx[j]  = w;
                m_rr[j]   = md;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin
                m_hold[j] = 0;
                m_idx[j]  = 0;
                m_ptr[j]  = m_n[j] - 1;
                m_rr[j]   = 0;
            end
        end else begin
            model_step(0, 64'(if8.req), if8.mode, if8.grant_ready);
            model_step(1, 64'(if5.req), if5.mode, if5.grant_ready);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_model(input int j, input logic v, input logic b,
                             input logic [63:0] idx, input logic [63:0] oh);
        logic [63:0] exp_oh;
        exp_oh = m_hold[j] ? (64'd1 << m_idx[j]) : 64'd0;
        chk($sformatf("model_valid[N=%0d]", m_n[j]), 64'(v), 64'(m_hold[j]));
        chk($sformatf("model_busy[N=%0d]", m_n[j]), 64'(b), 64'(m_hold[j]));
        chk($sformatf("model_idx[N=%0d]", m_n[j]), idx, 64'(m_idx[j]));
        chk($sformatf("model_onehot[N=%0d]", m_n[j]), oh, exp_oh);
    endtask

    // single compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        cmp_model(0, if8.grant_valid, if8.busy, 64'(if8.grant_idx), 64'(if8.grant_onehot));
        cmp_model(1, if5.grant_valid, if5.busy, 64'(if5.grant_idx), 64'(if5.grant_onehot));
    end

    // ---------------- stimulus helpers ----------------
    int grants[$];

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic collect(input int which, input int cnt);
        grants.delete();
        for (int c = 0; c < 200 && grants.size() < cnt; c++) begin
            @(negedge clk);
            if (which == 0) begin
                if (if8.grant_valid && if8.grant_ready) grants.push_back(int'(if8.grant_idx));
            end else begin
                if (if5.grant_valid && if5.grant_ready) grants.push_back(int'(if5.grant_idx));
            end
        end
        chk("collect_count", 64'(grants.size()), 64'(cnt));
    endtask

    task automatic wait_valid8();
        int c;
        c = 0;
        while (!if8.grant_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("wait_valid8", 64'(if8.grant_valid), 64'd1);
    endtask

    initial begin
        int exp_rr[9];
        int exp_mix[4];
        int exp5[3];
        exp_rr  = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        exp_mix = '{7, 7, 0, 7};
        exp5    = '{4, 0, 4};

        rst_n = 1'b1;
        if8.mode = 1'b0; if8.req = '0; if8.grant_ready = 1'b0;
        if5.mode = 1'b0; if5.req = '0; if5.grant_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("reset_valid", 64'(if8.grant_valid), 64'd0);
        chk("reset_busy", 64'(if8.busy), 64'd0);
        chk("reset_idx", 64'(if8.grant_idx), 64'd0);
        chk("reset_onehot", 64'(if8.grant_onehot), 64'd0);

        // fixed priority, one-cycle latency, handshake drops valid
        if8.mode = 1'b0; if8.req = 8'b0010_0110; if8.grant_ready = 1'b1;
        @(negedge clk);
        chk("fix_valid", 64'(if8.grant_valid), 64'd1);
        chk("fix_idx", 64'(if8.grant_idx), 64'd5);
        chk("fix_onehot", 64'(if8.grant_onehot), 64'h20);
        if8.req = '0;
        @(negedge clk);
        chk("fix_valid_after", 64'(if8.grant_valid), 64'd0);

        // sticky grant under stall, req change in HOLD ignored
        if8.req = 8'h81; if8.grant_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("stall_idx", 64'(if8.grant_idx), 64'd7);
            chk("stall_busy", 64'(if8.busy), 64'd1);
            if (c == 2) if8.req = 8'h01;
        end
        if8.grant_ready = 1'b1; if8.req = '0;
        @(negedge clk);
        chk("stall_release", 64'(if8.grant_valid), 64'd0);

        // no requests: nothing presented, index retained
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_valid", 64'(if8.grant_valid), 64'd0);
            chk("idle_busy", 64'(if8.busy), 64'd0);
            chk("idle_idx", 64'(if8.grant_idx), 64'd7);
        end

        // round-robin full rotation
        do_reset();
        if8.mode = 1'b1; if8.req = 8'hFF; if8.grant_ready = 1'b1;
        collect(0, 9);
        for (int i = 0; i < 9; i++) chk($sformatf("rr_seq[%0d]", i), 64'(grants[i]), 64'(exp_rr[i]));

        // 0x81 alternation with mode switch; ptr preserved across fixed mode
        if8.req = '0;
        do_reset();
        if8.mode = 1'b1; if8.req = 8'h81; if8.grant_ready = 1'b1;
        collect(0, 3);
        chk("alt_0", 64'(grants[0]), 64'd7);
        chk("alt_1", 64'(grants[1]), 64'd0);
        chk("alt_2", 64'(grants[2]), 64'd7);
        if8.mode = 1'b0;
        collect(0, 1);
        chk("mix_fixed", 64'(grants[0]), 64'(exp_mix[1]));
        if8.mode = 1'b1;
        collect(0, 2);
        chk("mix_rr_0", 64'(grants[0]), 64'(exp_mix[2]));
        chk("mix_rr_1", 64'(grants[1]), 64'(exp_mix[3]));

        // asynchronous reset while holding idx 3
        if8.req = '0;
        @(negedge clk);
        @(negedge clk);
        if8.mode = 1'b0; if8.req = 8'h08; if8.grant_ready = 1'b0;
        @(negedge clk);
        wait_valid8();
        chk("hold3_idx", 64'(if8.grant_idx), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(if8.grant_valid), 64'd0);
        chk("async_onehot", 64'(if8.grant_onehot), 64'd0);
        chk("async_busy", 64'(if8.busy), 64'd0);
        if8.req = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // N=5 round-robin wrap
        if5.mode = 1'b1; if5.req = 5'b10001; if5.grant_ready = 1'b1;
        collect(1, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("n5_seq[%0d]", i), 64'(grants[i]), 64'(exp5[i]));
        if5.req = '0;

        // randomized traffic on both instances, rare resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end else begin
                if8.mode = 1'($urandom_range(0, 1));
                if5.mode = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       if8.req = '0;
                    1:       if8.req = 8'd1 << $urandom_range(0, 7);
                    default: if8.req = 8'($urandom);
                endcase
                case ($urandom_range(0, 3))
                    0:       if5.req = '0;
                    1:       if5.req = 5'd1 << $urandom_range(0, 4);
                    default: if5.req = 5'($urandom);
                endcase
                if8.grant_ready = ($urandom_range(0, 3) != 0);
                if5.grant_ready = ($urandom_range(0, 3) != 0);
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/prio_arbiter.md
Name: prio_arbiter

Overview:
- Parametrised, registered priority arbiter: successor to the combinational 8-bit priority encoder.
- Picks one of N request lines in either fixed-priority mode (highest index wins) or round-robin mode.
- Presents the winner as an index plus a one-hot vector behind a valid/ready handshake.
- Holds the grant stable until the downstream consumer accepts it.
- Used wherever shared resources need fair or strict-order selection among requesters.

Parameters:
- N, 8, number of request lines; legal range 2..64.
- IDX_W, 3, width of grant index; must equal clog2(N).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = fixed priority (index N-1 highest), 1 = round-robin.
- req  in  N  request vector; bit i set = requester i wants a grant.
- grant_valid  out  1  a grant is being presented.
- grant_ready  in  1  downstream accepts the grant this cycle.
- grant_idx  out  IDX_W  binary index of granted requester.
- grant_onehot  out  N  one-hot of granted requester.
- busy  out  1  high while in HOLD state.

Behaviour:
- Reset (async assert, sync-safe deassert on clk):
  - state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, busy=0, ptr=N-1.
- FSM states:
  - IDLE: no grant presented.
    - If req!=0, latch winner into grant_idx/grant_onehot, set grant_valid=1, go to HOLD.
    - If req==0, stay in IDLE with outputs unchanged (grant_valid=0).
  - HOLD: grant_valid=1, busy=1; grant_idx and grant_onehot frozen.
    - On grant_valid&grant_ready: clear grant_valid and grant_onehot, go to IDLE; grant_idx retains its last value.
    - Without grant_ready: stay in HOLD indefinitely.
- Latency and throughput:
  - req sampled at edge k appears as grant_valid at edge k+1.
  - After a handshake, one mandatory idle cycle follows, so the maximum rate is one grant per 2 cycles.
- Fixed mode: winner = highest set index of req (same priority order as the 8-bit encoder, generalised to N).
- Round-robin mode:
  - Search starts at ptr and descends with wrap (ptr, ptr-1, ..., 0, N-1, ..., ptr+1).
  - First set bit found wins.
  - On handshake, ptr <= (winner==0) ? N-1 : winner-1, so the last winner becomes lowest priority.
- ptr update rules:
  - ptr updates only on a handshake while mode=1.
  - In fixed mode ptr is untouched, so switching back to round-robin resumes where it left off.
- Sampling rules:
  - mode and req are sampled only in IDLE.
  - Changes to either while in HOLD have no effect on the presented grant.
- Withdrawn request: if the granted req bit drops while in HOLD, the grant stays asserted until the handshake (sticky grant, no revocation).
- grant_ready while grant_valid=0 is ignored.
- Output consistency: grant_onehot is always either 0 or exactly one bit, and always equals 1<<grant_idx whenever grant_valid=1.
- Reset during HOLD: outputs clear immediately (asynchronously), the pending grant is dropped, and ptr returns to N-1.
- N not a power of two: indices >= N are never produced, and ptr wrap goes to N-1, never to 2^IDX_W-1.

Test Plan:
- Reset then mode=0, req=8'b0010_0110, grant_ready=1 -> next cycle grant_valid=1, grant_idx=5, grant_onehot=8'b0010_0000; the cycle after, grant_valid=0.
- mode=0, req=8'h81, grant_ready=0 for 5 cycles, req changed to 8'h01 at cycle 2 -> grant_idx stays 7, busy=1 throughout; ready on cycle 6 -> grant_valid drops on the next edge.
- mode=1, req=8'hFF held, grant_ready=1 -> grants 7,6,5,4,3,2,1,0,7, each separated by one idle cycle.
- mode=1, req=8'b1000_0001 held, ready=1 -> grants alternate 7,0,7,0; switch to mode=0 mid-sequence -> next grant is 7, and the round-robin order resumes from the stored ptr when mode returns to 1.
- req=0 for 10 cycles -> grant_valid=0, busy=0, outputs unchanged; rst_n pulsed low during HOLD with grant_idx=3 -> grant_valid=0, grant_onehot=0 immediately, without waiting for a clock edge.
- N=5, IDX_W=3, mode=1, req=5'b10001 -> grants 4,0,4; grant_idx never exceeds 4.
